// File: rtl/sb_config_loader.sv
// ---------------------------------------------------------------------------
// sb_config_loader
//
// Purpose:
//   Upstream feeder for the switch-box array. It deserialises a 1-bit, MSB-first
//   configuration bitstream into (tile address, data word) frames. Each complete
//   frame writes its word into one switch box through a shared data bus and a
//   one-hot per-tile write strobe.
//
//   Frame on the wire: start bit '1', ADDR_WIDTH address bits, DATA_WIDTH data
//   bits, and one extra even-parity bit when SB_CONFIG_LOADER_PARITY_EN is
//   defined.
//
// Configuration macro:
//   SB_CONFIG_LOADER_PARITY_EN
//     defined   : a PARITY state takes one bit after the data. Even parity is
//                 required over addr+data+parity. A mismatch suppresses the write
//                 and sets err_parity. Parity is checked before the address range.
//     undefined : no parity bit, err_parity is tied to 0.
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   asynchronous, active-low reset
//   bs_bit       in   serial bitstream bit, MSB first
//   bs_valid     in   bs_bit valid
//   bs_ready     out  loader accepts a bit this cycle (low only in ISSUE)
//   config_data  out  word to the switch boxes, held between writes
//   config_en    out  one-hot write strobe, one cycle per accepted frame
//   busy         out  frame in progress (state != IDLE)
//   err_addr     out  sticky: a frame addressed a tile >= NUM_TILES
//   err_parity   out  sticky: parity mismatch (0 without the feature)
//   frames_done  out  number of frames written to a tile, wraps silently
// ---------------------------------------------------------------------------
module sb_config_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TILES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bs_bit,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  output logic [DATA_WIDTH-1:0] config_data,
  output logic [NUM_TILES-1:0]  config_en,
  output logic                  busy,
  output logic                  err_addr,
  output logic                  err_parity,
  output logic [15:0]           frames_done
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

`ifdef SB_CONFIG_LOADER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_PARITY,
    S_ISSUE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_sr_q, addr_sr_d;
  logic [DATA_WIDTH-1:0]   data_sr_q, data_sr_d;
  logic [DATA_WIDTH-1:0]   config_data_q, config_data_d;
  logic [NUM_TILES-1:0]    config_en_q, config_en_d;
  logic                    err_addr_q, err_addr_d;
  logic [15:0]             frames_done_q, frames_done_d;
`ifdef SB_CONFIG_LOADER_PARITY_EN
  logic                    err_parity_q, err_parity_d;
`endif

  logic                    xfer;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   commit_data;

  // The whole frame is complete on the same edge that enters ISSUE, so the
  // write strobe and data are registered on that edge and are visible during
  // the ISSUE cycle itself (one cycle after the last transferred bit).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_sr_d     = addr_sr_q;
    data_sr_d     = data_sr_q;
    config_data_d = config_data_q;
    config_en_d   = '0;
    err_addr_d    = err_addr_q;
    frames_done_d = frames_done_q;
`ifdef SB_CONFIG_LOADER_PARITY_EN
    err_parity_d  = err_parity_q;
`endif
    commit        = 1'b0;
    commit_data   = data_sr_q;
    xfer          = bs_valid && (state_q != S_ISSUE);

    case (state_q)
      S_IDLE: begin
        if (xfer && bs_bit) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          addr_sr_d = {addr_sr_q[ADDR_WIDTH-2:0], bs_bit};
          if (cnt_q == ADDR_LAST) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          data_sr_d = {data_sr_q[DATA_WIDTH-2:0], bs_bit};
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
`ifdef SB_CONFIG_LOADER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d     = S_ISSUE;
            commit      = 1'b1;
            commit_data = data_sr_d;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SB_CONFIG_LOADER_PARITY_EN
      S_PARITY: begin
        // Even parity: XOR over address, data and the parity bit must be 0.
        if (xfer) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          if (^{addr_sr_q, data_sr_q, bs_bit}) begin
            err_parity_d = 1'b1;
          end else begin
            commit      = 1'b1;
            commit_data = data_sr_q;
          end
        end
      end
`endif
      S_ISSUE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Out-of-range addresses leave the bus untouched and only flag the error.
    if (commit) begin
      if (32'(addr_sr_q) < 32'(NUM_TILES)) begin
        for (int i = 0; i < NUM_TILES; i++) begin
          config_en_d[i] = (32'(addr_sr_q) == 32'(i));
        end
        config_data_d = commit_data;
        frames_done_d = frames_done_q + 16'd1;
      end else begin
        err_addr_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_sr_q     <= '0;
      data_sr_q     <= '0;
      config_data_q <= '0;
      config_en_q   <= '0;
      err_addr_q    <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_sr_q     <= addr_sr_d;
      data_sr_q     <= data_sr_d;
      config_data_q <= config_data_d;
      config_en_q   <= config_en_d;
      err_addr_q    <= err_addr_d;
      frames_done_q <= frames_done_d;
    end
  end

`ifdef SB_CONFIG_LOADER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_parity_q <= 1'b0;
    end else begin
      err_parity_q <= err_parity_d;
    end
  end

  assign err_parity = err_parity_q;
`else
  assign err_parity = 1'b0;
`endif

  assign bs_ready    = (state_q != S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign config_data = config_data_q;
  assign config_en   = config_en_q;
  assign err_addr    = err_addr_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// ---------------------------------------------------------------------------
// tb_sb_config_loader
//
// Randomised and directed frames are driven into sb_config_loader. For every
// frame the bench works out, from the frame format alone, whether a tile write
// should happen. Writes are pushed onto a scoreboard queue together with the
// cycle in which the strobe must appear. An independent monitor pops the queue
// whenever config_en is non-zero and also checks that config_data holds its
// value between writes. Sticky flags, the frame counter and the bs_ready/busy
// behaviour during ISSUE are checked after each frame.
// ---------------------------------------------------------------------------
module tb_sb_config_loader;

  logic        clk;
  logic        reset;
  logic        bs_bit;
  logic        bs_valid;
  logic        bs_ready;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        busy;
  logic        err_addr;
  logic        err_parity;
  logic [15:0] frames_done;

  sb_config_loader #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .NUM_TILES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bs_bit     (bs_bit),
    .bs_valid   (bs_valid),
    .bs_ready   (bs_ready),
    .config_data(config_data),
    .config_en  (config_en),
    .busy       (busy),
    .err_addr   (err_addr),
    .err_parity (err_parity),
    .frames_done(frames_done)
  );

  typedef struct {
    logic [15:0] en;
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t        expQ[$];
  int          nChecks = 0;
  int          nErrors = 0;
  int          cyc = 0;
  logic [31:0] heldData = '0;
  int          modelFrames = 0;
  bit          modelErrAddr = 0;
  bit          modelErrPar = 0;
  int          lastCycle = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Offers one bit, optionally after idle (bs_valid=0) cycles, and holds it
  // until the loader is ready. The transfer happens at the following edge.
  task automatic applyStimulus(input logic b, input int stall);
    int gap;
    int waits;
    gap = 0;
    if (stall == 1) gap = 1;
    else if (stall == 2) gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(negedge clk);
      bs_valid = 1'b0;
      bs_bit   = 1'($urandom);
    end
    waits = 0;
    forever begin
      @(negedge clk);
      bs_valid = 1'b1;
      bs_bit   = b;
      if (bs_ready) break;
      waits++;
      if (waits > 100) begin
        checkOutput("ready_timeout", 64'(bs_ready), 64'd1);
        break;
      end
    end
    lastCycle = cyc;
  endtask

  // Sends one whole frame and updates the reference model from the frame
  // rules: bad parity beats bad address, and only in-range tiles are written.
  task automatic sendFrame(input logic [15:0] addr, input logic [31:0] data,
                           input int stall, input bit b2b, input bit badPar);
    exp_t e;
    bit   parOk;
    applyStimulus(1'b1, stall);
    for (int i = 15; i >= 0; i--) applyStimulus(addr[i], stall);
    for (int i = 31; i >= 0; i--) applyStimulus(data[i], stall);
    parOk = 1'b1;
`ifdef SB_CONFIG_LOADER_PARITY_EN
    applyStimulus((^{addr, data}) ^ badPar, stall);
    parOk = !badPar;
`else
    parOk = parOk | badPar;
`endif
    if (!parOk) begin
      modelErrPar = 1;
    end else if (addr >= 16) begin
      modelErrAddr = 1;
    end else begin
      e.en    = 16'(32'd1 << addr);
      e.data  = data;
      e.cycle = lastCycle + 1;
      expQ.push_back(e);
      modelFrames = (modelFrames + 1) % 65536;
    end
    // ISSUE cycle: loader refuses bits and is still busy.
    @(negedge clk);
    if (b2b) begin
      bs_valid = 1'b1;
      bs_bit   = 1'b1;
    end else begin
      bs_valid = 1'b0;
    end
    checkOutput("issue_bs_ready", 64'(bs_ready), 64'd0);
    checkOutput("issue_busy", 64'(busy), 64'd1);
    checkOutput("frames_done", 64'(frames_done), 64'(modelFrames));
    checkOutput("err_addr", 64'(err_addr), 64'(modelErrAddr));
    checkOutput("err_parity", 64'(err_parity), 64'(modelErrPar));
  endtask

  task automatic idleZeros(input int n);
    repeat (n) begin
      @(negedge clk);
      bs_valid = 1'b1;
      bs_bit   = 1'b0;
    end
  endtask

  // Asynchronous reset applied away from both clock edges.
  task automatic doReset();
    @(negedge clk);
    #1;
    reset    = 1'b0;
    bs_valid = 1'b0;
    expQ.delete();
    heldData     = '0;
    modelFrames  = 0;
    modelErrAddr = 0;
    modelErrPar  = 0;
    #1;
    checkOutput("rst_config_en", 64'(config_en), 64'd0);
    checkOutput("rst_config_data", 64'(config_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err_addr", 64'(err_addr), 64'd0);
    checkOutput("rst_err_parity", 64'(err_parity), 64'd0);
    checkOutput("rst_frames_done", 64'(frames_done), 64'd0);
    checkOutput("rst_bs_ready", 64'(bs_ready), 64'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Scoreboard monitor: consumes expected writes when the strobe appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (config_en !== 16'd0) begin
          if (expQ.size() == 0) begin
            checkOutput("spurious_config_en", 64'(config_en), 64'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("config_en", 64'(config_en), 64'(e.en));
            checkOutput("write_cycle", 64'(cyc), 64'(e.cycle));
            heldData = e.data;
          end
        end else if (expQ.size() > 0 && expQ[0].cycle < cyc) begin
          e = expQ.pop_front();
          checkOutput("missing_config_en", 64'(config_en), 64'(e.en));
        end
        checkOutput("config_data", 64'(config_data), 64'(heldData));
      end
    end
  end

  initial begin
    bit prevB2b;
    bit b2b;
    reset    = 1'b0;
    bs_valid = 1'b0;
    bs_bit   = 1'b0;
    #3;
    checkOutput("init_config_en", 64'(config_en), 64'd0);
    checkOutput("init_busy", 64'(busy), 64'd0);
    checkOutput("init_bs_ready", 64'(bs_ready), 64'd1);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] basic write");
    idleZeros(3);
    checkOutput("idle_zero_busy", 64'(busy), 64'd0);
    sendFrame(16'd3, 32'hDEADBEEF, 0, 0, 0);

    $display("[TB] bad address");
    idleZeros(2);
    sendFrame(16'd20, 32'h12345678, 0, 0, 0);

    $display("[TB] stalls on alternate cycles");
    idleZeros(1);
    sendFrame(16'd3, 32'hDEADBEEF, 1, 0, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 0);
    for (int i = 0; i < 19; i++) applyStimulus(1'($urandom), 0);
    doReset();
    sendFrame(16'd0, 32'h00000001, 0, 0, 0);

    $display("[TB] back-to-back");
    idleZeros(1);
    sendFrame(16'd15, 32'hA5A5F00F, 0, 1, 0);
    sendFrame(16'd7, 32'h0BADCAFE, 0, 0, 0);

`ifdef SB_CONFIG_LOADER_PARITY_EN
    $display("[TB] parity");
    idleZeros(1);
    sendFrame(16'd1, 32'h00000001, 0, 0, 1);
    idleZeros(1);
    sendFrame(16'd1, 32'h00000001, 0, 0, 0);
`endif

    $display("[TB] random frames");
    prevB2b = 0;
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(16, 65535));
      else a = 16'($urandom_range(0, 15));
      b2b = 1'($urandom_range(0, 3) == 0);
      if (!prevB2b) idleZeros($urandom_range(0, 3));
      sendFrame(a, $urandom, $urandom_range(0, 2), b2b,
                1'($urandom_range(0, 4) == 0));
      prevB2b = b2b;
    end

    @(negedge clk);
    bs_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
